// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the sequential 3-bit pattern scanner.
// Holds the FSM state encoding, default word width/pattern and the count-width helper.
package seq_scan_pkg;

    localparam int         DEF_WORD_W = 16;
    localparam logic [2:0] DEF_PAT    = 3'b101;

    // Legacy-compatible state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_SCAN = 2'b01;
    localparam state_t ST_DONE = 2'b10;

    // A word of word_w bits holds at most word_w-2 windows, so the count needs clog2(word_w-1) bits.
    function automatic int cnt_w(input int word_w);
        return $clog2(word_w - 1);
    endfunction

endpackage

// File: rtl/seq_win_match.sv
// Combinational window comparator: selects window idx of the word and compares it with PAT.
// Window idx is {word[idx], word[idx+1], word[idx+2]}, with word[idx] as the MSB.
module seq_win_match
    import seq_scan_pkg::*;
#(
    parameter int         WORD_W = DEF_WORD_W,
    parameter logic [2:0] PAT    = DEF_PAT,
    localparam int        IDX_W  = $clog2(WORD_W)
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic              match
);

    logic [2:0] window;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        window = 3'b000;
        for (int i = 0; i <= WORD_W - 3; i++) begin
            if (idx == IDX_W'(i)) begin
                window = {word[i], word[i+1], word[i+2]};
            end
        end
        match = (window == PAT);
    end

endmodule

// File: rtl/seq_scan_arb.sv
// Two-requester round-robin arbiter feeding a one-window-per-cycle pattern counter.
// Optional macro SEQ_SCAN_FASTZERO_EN: words with fewer than two set bits skip SCAN.
module seq_scan_arb
    import seq_scan_pkg::*;
#(
    parameter int         WORD_W = DEF_WORD_W,
    parameter logic [2:0] PAT    = DEF_PAT,
    localparam int        CNT_W  = cnt_w(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_id,
    input  logic              res_ready,
    output logic              busy
);

    localparam int               IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 3);

    state_t             state;
    logic               ptr;
    logic [WORD_W-1:0]  word;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   count;
    logic               id;

    logic               grant_valid;
    logic               grant_id;
    logic               accept;
    logic [WORD_W-1:0]  accept_data;
    logic               match;
    logic               sparse;

    // ptr=0 prefers requester 0; a lone valid requester always wins.
    // Readys are gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = req1_valid & (~req0_valid | ptr);
        accept      = (state == ST_IDLE) & grant_valid & rst_n;
        req0_ready  = accept & ~grant_id;
        req1_ready  = accept & grant_id;
        accept_data = grant_id ? req1_data : req0_data;
`ifdef SEQ_SCAN_FASTZERO_EN
        sparse      = ($countones(accept_data) < 2);
`else
        sparse      = 1'b0;
`endif
    end

    seq_win_match #(
        .WORD_W (WORD_W),
        .PAT    (PAT)
    ) u_win_match (
        .word  (word),
        .idx   (idx),
        .match (match)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
            word  <= '0;
            idx   <= '0;
            count <= '0;
            id    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word  <= accept_data;
                        id    <= grant_id;
                        count <= '0;
                        idx   <= '0;
                        ptr   <= ~grant_id;
                        state <= sparse ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    count <= count + CNT_W'(match);
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = (state == ST_DONE);
    assign res_count = count;
    assign res_id    = id;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_seq_scan_arb.sv
// Self-checking bench for seq_scan_arb: table-driven transfers with a result scoreboard,
// plus hand-written round-robin, result-stall and mid-scan reset sequences.
module tb_seq_scan_arb;

    localparam int WORD_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [WORD_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              res_valid;
    logic [3:0]        res_count;
    logic              res_id;
    logic              res_ready;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        sel;
        logic [15:0] data;
        logic [3:0]  exp_count;
    } vec_t;

    typedef struct {
        logic       id;
        logic [3:0] count;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    seq_scan_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_count  (res_count),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] model_count(input logic [15:0] d);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i <= 13; i++) begin
            if ({d[i], d[i+1], d[i+2]} == 3'b101) c = c + 4'd1;
        end
        return c;
    endfunction

    // Edges from the accept edge (edge 0) until res_valid is visible.
    function automatic int exp_lat(input logic [15:0] d);
`ifdef SEQ_SCAN_FASTZERO_EN
        if ($countones(d) < 2) return 0;
`endif
        return WORD_W - 2;
    endfunction

    function automatic logic sel_ready(input logic sel);
        return sel ? req1_ready : req0_ready;
    endfunction

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_txn(input logic sel, input logic [15:0] data, input logic [3:0] exp_cnt,
                           input string name);
        int   waited;
        int   lat;
        exp_t e;
        if (sel) begin req1_valid = 1'b1; req1_data = data; end
        else     begin req0_valid = 1'b1; req0_data = data; end
        #1;
        waited = 0;
        while (!sel_ready(sel) && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check({name, " accept"}, 32'(waited < 20), 32'd1);
        if (waited >= 20) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        check({name, " other ready"}, 32'(sel_ready(~sel)), 32'd0);
        sb.push_back('{id: sel, count: exp_cnt});
        @(posedge clk);
        @(negedge clk);
        // Corrupt the offered data after the accept edge: the block must have sampled it already.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = ~data; req1_data = ~data;
        #1;
        check({name, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat(data)));
        if (res_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({name, " count"}, 32'(res_count), 32'(e.count));
            check({name, " id"},    32'(res_id),    32'(e.id));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check({name, " idle after handshake"}, 32'({res_valid, busy}), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int         grants;
        int         cyc;
        logic       bad;
        logic [15:0] rw;

        vecs[0] = '{sel: 1'b0, data: 16'b1010000000000101, exp_count: 4'd2};
        vecs[1] = '{sel: 1'b1, data: 16'b1011011011010101, exp_count: 4'd6};
        vecs[2] = '{sel: 1'b1, data: 16'hAAAA,             exp_count: 4'd7};
        vecs[3] = '{sel: 1'b0, data: 16'h0000,             exp_count: 4'd0};
        vecs[4] = '{sel: 1'b0, data: 16'hFFFF,             exp_count: 4'd0};
        vecs[5] = '{sel: 1'b1, data: 16'h0001,             exp_count: 4'd0};
        vecs[6] = '{sel: 1'b0, data: 16'h5555,             exp_count: 4'd7};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = vecs[0].data;
        req1_valid = 1'b1; req1_data = 16'h1234;
        res_ready = 1'b0;

        // Reset state with both requesters offering.
        repeat (3) @(negedge clk);
        #1;
        check("reset req0_ready", 32'(req0_ready), 32'd0);
        check("reset req1_ready", 32'(req1_ready), 32'd0);
        check("reset res_valid",  32'(res_valid),  32'd0);
        check("reset res_count",  32'(res_count),  32'd0);
        check("reset res_id",     32'(res_id),     32'd0);
        check("reset busy",       32'(busy),       32'd0);
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first edge ready", 32'(req0_ready), 32'd1);

        // Table-driven transfers (vecs[0] starts with valid already high from reset).
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].sel, vecs[i].data, vecs[i].exp_count, $sformatf("vec%0d", i));
        end

        // Random words against the reference model.
        for (int i = 0; i < 4; i++) begin
            rw = 16'($urandom);
            run_txn(1'(i % 2), rw, model_count(rw), $sformatf("rand%0d", i));
        end

        // Round robin with both valid continuously after reset.
        pulse_reset();
        req0_valid = 1'b1; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_data = 16'h5555;
        res_ready  = 1'b1;
        grants = 0; cyc = 0; bad = 1'b0;
        #1;
        while (grants < 4 && cyc < 200) begin
            if (req0_ready || req1_ready) begin
                check($sformatf("rr one-hot %0d", grants), 32'(req0_ready ^ req1_ready), 32'd1);
                check($sformatf("rr grant %0d", grants), 32'(req1_ready), 32'(grants % 2));
                grants++;
            end else if (busy && (req0_ready || req1_ready)) begin
                bad = 1'b1;
            end
            @(negedge clk); #1;
            if (busy && (req0_ready || req1_ready)) bad = 1'b1;
            cyc++;
        end
        check("rr grants seen", 32'(grants), 32'd4);
        check("rr readys low while busy", 32'(bad), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;

        // Result stall: res_ready low for 5 cycles with requester 1 waiting.
        pulse_reset();
        req0_valid = 1'b1; req0_data = 16'b1010000000000101;
        #1;
        check("stall ready", 32'(req0_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 16'hFFFF;
        cyc = 0;
        #1;
        while (!res_valid && cyc < 40) begin @(negedge clk); #1; cyc++; end
        check("stall latency", 32'(cyc), 32'(exp_lat(16'b1010000000000101)));
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (!res_valid || res_count != 4'd2 || res_id != 1'b0 || req0_ready || req1_ready)
                bad = 1'b1;
        end
        check("stall hold stable", 32'(bad), 32'd0);
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready  = 1'b0;
        #1;
        check("stall idle busy", 32'(busy), 32'd0);
        check("stall idle res_valid", 32'(res_valid), 32'd0);
        check("stall idle req1_ready", 32'(req1_ready), 32'd1);
        req1_valid = 1'b0;

        // Reset asserted at SCAN index 7.
        pulse_reset();
        req0_valid = 1'b1; req0_data = 16'hAAAA;
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check("midscan busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("midscan reset outputs",
              32'({res_valid, res_count, res_id, busy, req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (res_valid || busy) bad = 1'b1;
        end
        check("midscan no stale result", 32'(bad), 32'd0);
        run_txn(1'b1, 16'b1011011011010101, 4'd6, "post-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
